pmem_burst_adapter: RTL and testbench



---
 rtl/pmem_burst_pkg.sv | 23 ++
 rtl/burst_line_buffer.sv | 39 +++
 rtl/pmem_burst_adapter.sv | 114 +++++++++++
 tb/tb_pmem_burst_adapter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_burst_pkg.sv
// Shared types and constants for the 256-bit line to 64-bit burst adapter.
package pmem_burst_pkg;

   localparam int LINE_WIDTH  = 256;
   localparam int BEAT_WIDTH  = 64;
   localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
   localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

   typedef logic [$clog2(BEATS)-1:0] beat_idx_t;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } state_t;

   // Clears the byte-offset bits so bursts always start on a line boundary.
   function automatic logic [31:0] line_align(input logic [31:0] addr);
      return addr & ~((32'd1 << OFFSET_BITS) - 32'd1);
   endfunction

endpackage

// File: rtl/burst_line_buffer.sv
// Line storage for the burst adapter: beat-indexed assembly of read lines and
// beat-indexed serialization of a latched write line.
module burst_line_buffer
   import pmem_burst_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [LINE_WIDTH-1:0] line_in,
   input  logic                  beat_we,
   input  logic [BEAT_WIDTH-1:0] beat_in,
   input  logic [1:0]            idx,
   output logic [LINE_WIDTH-1:0] rd_line,
   output logic [BEAT_WIDTH-1:0] wr_beat
);

   logic [LINE_WIDTH-1:0] wr_line;

   // Read and write lines are kept apart so a write burst never disturbs the
   // last assembled read line.
   // NOTE: both line registers take the synchronous reset; a reset mid-burst
   // must discard partial data and leave pmem_rdata reading zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_line <= '0;
         wr_line <= '0;
      end else begin
         if (beat_we) begin
            rd_line[BEAT_WIDTH*idx +: BEAT_WIDTH] <= beat_in;
         end
         if (load) begin
            wr_line <= line_in;
         end
      end
   end

   assign wr_beat = wr_line[BEAT_WIDTH*idx +: BEAT_WIDTH];

endmodule

// File: rtl/pmem_burst_adapter.sv
// Converts L2 line requests into four-beat 64-bit bursts toward memory and
// completes each request with a one-cycle pmem_resp.
module pmem_burst_adapter
   import pmem_burst_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         pmem_read,
   input  logic         pmem_write,
   input  logic [31:0]  pmem_address,
   input  logic [255:0] pmem_wdata,
   output logic [255:0] pmem_rdata,
   output logic         pmem_resp,
   input  logic [63:0]  burst_i,
   input  logic         resp_i,
   output logic [63:0]  burst_o,
   output logic [31:0]  address_o,
   output logic         read_o,
   output logic         write_o
);

   state_t                state, state_next;
   beat_idx_t             cnt, cnt_next;
   logic [31:0]           addr;
   logic                  load_addr;
   logic                  load_line;
   logic                  beat_we;
   logic [BEAT_WIDTH-1:0] wr_beat;

   // NOTE: non-blocking assignments so every register updates from the same
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         addr  <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (load_addr) begin
            addr <= line_align(pmem_address);
         end
      end
   end

   // NOTE: every signal driven here gets a default first, so no branch can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      load_addr  = 1'b0;
      load_line  = 1'b0;
      beat_we    = 1'b0;
      case (state)
         IDLE: begin
            // A simultaneous read and write is illegal; write takes priority.
            if (pmem_write) begin
               state_next = WRITE;
               cnt_next   = '0;
               load_addr  = 1'b1;
               load_line  = 1'b1;
            end else if (pmem_read) begin
               state_next = READ;
               cnt_next   = '0;
               load_addr  = 1'b1;
            end
         end
         READ: begin
            if (resp_i) begin
               beat_we  = 1'b1;
               cnt_next = cnt + beat_idx_t'(1);
               if (cnt == beat_idx_t'(BEATS - 1)) begin
                  state_next = DONE;
               end
            end
         end
         WRITE: begin
            if (resp_i) begin
               cnt_next = cnt + beat_idx_t'(1);
               if (cnt == beat_idx_t'(BEATS - 1)) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   burst_line_buffer u_line_buffer (
      .clk     (clk),
      .rst     (rst),
      .load    (load_line),
      .line_in (pmem_wdata),
      .beat_we (beat_we),
      .beat_in (burst_i),
      .idx     (cnt),
      .rd_line (pmem_rdata),
      .wr_beat (wr_beat)
   );

   // Command outputs are decoded from state only; resp_i never reaches them
   // combinationally.
   assign read_o    = (state == READ);
   assign write_o   = (state == WRITE);
   assign pmem_resp = (state == DONE);
   assign address_o = addr;
   assign burst_o   = (state == WRITE) ? wr_beat : '0;

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Self-checking bench for pmem_burst_adapter: transaction-level model of line
// requests and memory beats, compared against the DUT every cycle.
module tb_pmem_burst_adapter;

   logic         clk = 1'b0;
   logic         rst;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;
   logic [63:0]  burst_i;
   logic         resp_i;
   logic [63:0]  burst_o;
   logic [31:0]  address_o;
   logic         read_o;
   logic         write_o;

   pmem_burst_adapter dut (
      .clk          (clk),
      .rst          (rst),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .burst_i      (burst_i),
      .resp_i       (resp_i),
      .burst_o      (burst_o),
      .address_o    (address_o),
      .read_o       (read_o),
      .write_o      (write_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Expected outputs for the current cycle, maintained by the stimulus.
   bit           chk_en = 1'b0;
   logic         exp_read, exp_write, exp_resp;
   logic [31:0]  exp_addr;
   logic [63:0]  exp_burst;
   logic [255:0] exp_rdata;

   // Observations of the DUT used by the literal checks.
   int          cyc = 0;
   int          req_stamp = 0;
   int          resp_stamp = -1;
   int          resp_count = 0;
   int          cmd_stamp = -1;
   int          read_cycles = 0;
   logic [31:0] cmd_addr = '0;
   bit          prev_cmd = 1'b0;
   logic [63:0] wq[$];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (chk_en) begin
         check("read_o", read_o, exp_read);
         check("write_o", write_o, exp_write);
         check("pmem_resp", pmem_resp, exp_resp);
         check("pmem_rdata", pmem_rdata, exp_rdata);
         if (exp_read || exp_write) check("address_o", address_o, exp_addr);
         if (exp_write) check("burst_o", burst_o, exp_burst);
      end
   end

   always @(negedge clk) begin
      if (pmem_resp === 1'b1) begin
         resp_count++;
         resp_stamp = cyc;
      end
      if ((read_o | write_o) === 1'b1 && !prev_cmd) begin
         cmd_stamp = cyc;
         cmd_addr  = address_o;
      end
      prev_cmd = ((read_o | write_o) === 1'b1);
      if (read_o === 1'b1) read_cycles++;
      if (write_o === 1'b1 && resp_i === 1'b1) wq.push_back(burst_o);
   end

   function automatic logic [255:0] rand_line();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      resp_i     = 1'($urandom_range(0, 1));
      burst_i    = {$urandom, $urandom};
      exp_read   = 1'b0;
      exp_write  = 1'b0;
      exp_resp   = 1'b0;
      step();
   endtask

   // One line request. pat bit i gives resp_i for burst cycle i+1 after the
   // request cycle; pat == 0 means random beat timing. abort_after > 0 pulses
   // rst once that many beats have been accepted.
   task automatic txn(input bit is_wr, input bit both, input logic [31:0] addr,
                      input logic [255:0] line, input logic [31:0] pat, input int abort_after);
      logic [63:0] beats[4];
      int n;
      int c;
      bit r;
      for (int i = 0; i < 4; i++) beats[i] = line[64*i +: 64];
      pmem_read    = !is_wr || both;
      pmem_write   = is_wr;
      pmem_address = addr;
      pmem_wdata   = is_wr ? line : rand_line();
      resp_i       = 1'($urandom_range(0, 1));
      burst_i      = {$urandom, $urandom};
      exp_read     = 1'b0;
      exp_write    = 1'b0;
      exp_resp     = 1'b0;
      req_stamp    = cyc;
      step();
      n = 0;
      c = 1;
      while (n < 4) begin
         exp_read  = !is_wr;
         exp_write = is_wr;
         exp_resp  = 1'b0;
         exp_addr  = {addr[31:5], 5'b0};
         exp_burst = is_wr ? beats[n] : 64'h0;
         if (abort_after > 0 && n == abort_after) begin
            rst        = 1'b1;
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
            resp_i     = 1'($urandom_range(0, 1));
            step();
            rst       = 1'b0;
            exp_read  = 1'b0;
            exp_write = 1'b0;
            exp_resp  = 1'b0;
            exp_rdata = '0;
            idle_cycle();
            return;
         end
         r       = (pat != 0) ? pat[c-1] : (c > 40 || $urandom_range(0, 2) != 0);
         resp_i  = r;
         burst_i = is_wr ? {$urandom, $urandom} : beats[n];
         step();
         if (r) begin
            if (!is_wr) exp_rdata[64*n +: 64] = beats[n];
            n++;
         end
         c++;
      end
      exp_read  = 1'b0;
      exp_write = 1'b0;
      exp_resp  = 1'b1;
      resp_i    = 1'($urandom_range(0, 1));
      burst_i   = {$urandom, $urandom};
      step();
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
   endtask

   localparam logic [255:0] LINE_RD = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] LINE_WR = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

   initial begin
      int rc0;
      int rs;
      int rdc0;
      int kind;
      int ab;
      logic [63:0] wexp[4];
      wexp = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
               64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};

      rst          = 1'b1;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      burst_i      = '0;
      resp_i       = 1'b0;
      repeat (2) step();
      rst       = 1'b0;
      exp_read  = 1'b0;
      exp_write = 1'b0;
      exp_resp  = 1'b0;
      exp_addr  = '0;
      exp_burst = '0;
      exp_rdata = '0;
      chk_en    = 1'b1;
      check("reset address_o", address_o, 32'h0);
      check("reset burst_o", burst_o, 64'h0);
      idle_cycle();

      // Consecutive read beats.
      rc0 = resp_count;
      txn(1'b0, 1'b0, 32'h0000_1234, LINE_RD, 32'hF, 0);
      check("read1 address", cmd_addr, 32'h0000_1220);
      check("read1 latency", resp_stamp - req_stamp, 5);
      check("read1 pulses", resp_count - rc0, 1);
      check("read1 line", pmem_rdata, LINE_RD);
      idle_cycle();

      // Read with beats at +2, +4, +5, +9.
      rc0 = resp_count;
      txn(1'b0, 1'b0, 32'h8000_00FF, LINE_RD, 32'h0000_011A, 0);
      check("read2 latency", resp_stamp - req_stamp, 10);
      check("read2 pulses", resp_count - rc0, 1);
      check("read2 line", pmem_rdata, LINE_RD);
      idle_cycle();

      // Write with acceptance every other cycle.
      wq.delete();
      txn(1'b1, 1'b0, 32'h0000_4000, LINE_WR, 32'h0000_00AA, 0);
      check("write beats", wq.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < wq.size()) check("write beat order", wq[i], wexp[i]);
      end
      check("write keeps rdata", pmem_rdata, LINE_RD);
      idle_cycle();

      // Back-to-back read then write.
      txn(1'b0, 1'b0, $urandom, rand_line(), 32'h0, 0);
      rs = resp_stamp;
      txn(1'b1, 1'b0, $urandom, rand_line(), 32'h0, 0);
      check("b2b gap", cmd_stamp - rs, 2);
      idle_cycle();

      // Reset after two read beats, then a fresh read.
      rc0 = resp_count;
      txn(1'b0, 1'b0, 32'h0000_2000, rand_line(), 32'hF, 2);
      check("abort pulses", resp_count - rc0, 0);
      check("abort rdata", pmem_rdata, 256'h0);
      txn(1'b0, 1'b0, 32'h0000_3000, rand_line(), 32'h0, 0);
      idle_cycle();

      // Read and write together: write wins.
      rdc0 = read_cycles;
      txn(1'b1, 1'b1, $urandom, rand_line(), 32'h0, 0);
      check("both read_o cycles", read_cycles - rdc0, 0);
      idle_cycle();

      // Randomized mix.
      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 9);
         ab   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
         txn(kind < 5, kind == 4, $urandom, rand_line(), 32'h0, ab);
         repeat ($urandom_range(0, 2)) idle_cycle();
      end
      idle_cycle();

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
